// File: rtl/gen_secuencia_pkg.sv
// gen_secuencia_pkg: shared types and phase codes for the a/b sequence
// generator.
//   estado_t : FSM states (IDLE, P1..P4)
//   dir_t    : sequence direction (ingress / egress)
//   COD_*    : {a,b} code driven during each phase
package gen_secuencia_pkg;

    typedef enum logic [2:0] {IDLE, P1, P2, P3, P4} estado_t;
    typedef enum logic {DIR_INGRESO, DIR_EGRESO} dir_t;

    localparam logic [1:0] COD_ING_P1 = 2'b10;
    localparam logic [1:0] COD_ING_P2 = 2'b11;
    localparam logic [1:0] COD_ING_P3 = 2'b01;
    localparam logic [1:0] COD_ING_P4 = 2'b00;
    localparam logic [1:0] COD_EGR_P1 = 2'b01;
    localparam logic [1:0] COD_EGR_P2 = 2'b11;
    localparam logic [1:0] COD_EGR_P3 = 2'b10;
    localparam logic [1:0] COD_EGR_P4 = 2'b00;

    // {a,b} for a given phase and direction; IDLE drives 00
    function automatic logic [1:0] codigo(estado_t e, dir_t d);
        logic [1:0] c;
        c = 2'b00;
        case (e)
            P1:      c = (d == DIR_INGRESO) ? COD_ING_P1 : COD_EGR_P1;
            P2:      c = (d == DIR_INGRESO) ? COD_ING_P2 : COD_EGR_P2;
            P3:      c = (d == DIR_INGRESO) ? COD_ING_P3 : COD_EGR_P3;
            P4:      c = (d == DIR_INGRESO) ? COD_ING_P4 : COD_EGR_P4;
            default: c = 2'b00;
        endcase
        return c;
    endfunction

    // phase that follows e within a sequence (P4 exits to IDLE)
    function automatic estado_t siguiente(estado_t e);
        estado_t s;
        s = IDLE;
        case (e)
            P1:      s = P2;
            P2:      s = P3;
            P3:      s = P4;
            default: s = IDLE;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/gen_secuencia_ab_div_paso.sv
// div_paso: per-phase step counter.
//   clk, reset : system clock, async active-high reset
//   load       : restart the count at 0 (phase change / sequence start)
//   en         : count while a sequence is running
//   fin_paso   : high during the last cycle of a phase (count == STEP_CYCLES-1)
module div_paso #(
    parameter int STEP_CYCLES = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic en,
    output logic fin_paso
);

    localparam int CW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
    localparam logic [CW-1:0] ULT = CW'(STEP_CYCLES - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            cnt <= '0;
        else if (load)
            cnt <= '0;
        else if (en)
            cnt <= cnt + CW'(1);
    end

    // with STEP_CYCLES=1 the count sits at 0 and every running cycle ends a phase
    assign fin_paso = en && (cnt == ULT);

endmodule

// File: rtl/gen_secuencia_ab.sv
// gen_secuencia_ab: drives a/b through the four-phase Gray sequence for an
// ingress or egress request and keeps a saturating occupancy count.
//   clk, reset              : system clock, async active-high reset
//   req_ingreso, req_egreso : single-cycle requests
//   a, b                    : sensor levels (registered)
//   busy                    : sequence in progress
//   done                    : one-cycle pulse as a sequence completes
//   conflicto               : one-cycle pulse when both requests arrive together
//   perdida                 : sticky, a request was dropped
//   ocupacion               : net completed passages, saturating
// Build option: GEN_SEC_QUEUE_EN adds a one-entry pending-request buffer so a
// request arriving mid-sequence chains back-to-back at the P4 exit.
module gen_secuencia_ab
    import gen_secuencia_pkg::*;
#(
    parameter int STEP_CYCLES = 4,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_ingreso,
    input  logic             req_egreso,
    output logic             a,
    output logic             b,
    output logic             busy,
    output logic             done,
    output logic             conflicto,
    output logic             perdida,
    output logic [CNT_W-1:0] ocupacion
);

    estado_t estado;
    dir_t    dir;
    logic    fin_paso;
    logic    ambos, uno, sale, load;
    dir_t    d_req;

`ifdef GEN_SEC_QUEUE_EN
    logic    pend_v;
    dir_t    pend_dir;
`endif

    assign ambos = req_ingreso & req_egreso;
    assign uno   = req_ingreso ^ req_egreso;
    assign d_req = req_egreso ? DIR_EGRESO : DIR_INGRESO;
    assign sale  = (estado == P4) && fin_paso;
    // counter restarts on sequence start and on every phase change
    assign load  = ((estado == IDLE) && uno) || fin_paso;

    div_paso #(.STEP_CYCLES(STEP_CYCLES)) u_div_paso (
        .clk      (clk),
        .reset    (reset),
        .load     (load),
        .en       (estado != IDLE),
        .fin_paso (fin_paso)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            estado    <= IDLE;
            dir       <= DIR_INGRESO;
            a         <= 1'b0;
            b         <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            conflicto <= 1'b0;
            perdida   <= 1'b0;
            ocupacion <= '0;
`ifdef GEN_SEC_QUEUE_EN
            pend_v    <= 1'b0;
            pend_dir  <= DIR_INGRESO;
`endif
        end else begin
            done      <= 1'b0;
            conflicto <= ambos;
            if (estado == IDLE) begin
                if (uno) begin
                    estado <= P1;
                    dir    <= d_req;
                    {a, b} <= codigo(P1, d_req);
                    busy   <= 1'b1;
                end
            end else begin
                // request while busy (the exit edge counts as busy)
`ifdef GEN_SEC_QUEUE_EN
                if (uno) begin
                    if (pend_v)
                        perdida <= 1'b1;
                    else if (!sale) begin
                        pend_v   <= 1'b1;
                        pend_dir <= d_req;
                    end
                end
`else
                if (uno)
                    perdida <= 1'b1;
`endif
                if (sale) begin
                    done <= 1'b1;
                    if (dir == DIR_INGRESO) begin
                        if (ocupacion != '1)
                            ocupacion <= ocupacion + CNT_W'(1);
                    end else begin
                        if (ocupacion != '0)
                            ocupacion <= ocupacion - CNT_W'(1);
                    end
`ifdef GEN_SEC_QUEUE_EN
                    // buffered request wins; a request on the exit edge with an
                    // empty buffer would be stored, so chain it directly instead
                    if (pend_v) begin
                        estado <= P1;
                        dir    <= pend_dir;
                        {a, b} <= codigo(P1, pend_dir);
                        pend_v <= 1'b0;
                    end else if (uno) begin
                        estado <= P1;
                        dir    <= d_req;
                        {a, b} <= codigo(P1, d_req);
                    end else begin
                        estado <= IDLE;
                        {a, b} <= 2'b00;
                        busy   <= 1'b0;
                    end
`else
                    estado <= IDLE;
                    {a, b} <= 2'b00;
                    busy   <= 1'b0;
`endif
                end else if (fin_paso) begin
                    estado <= siguiente(estado);
                    {a, b} <= codigo(siguiente(estado), dir);
                end
            end
        end
    end

endmodule

// File: tb/tb_gen_secuencia_ab.sv
// Self-checking bench for gen_secuencia_ab (STEP_CYCLES=2, CNT_W=3).
// A timeline model (sequence start cycle, direction, pending entry) predicts
// the outputs every cycle; completed sequences are scoreboarded by cycle and
// resulting occupancy.
module tb_gen_secuencia_ab;

    localparam int STEP = 2;
    localparam int CW   = 3;
    localparam int SEQ  = 4 * STEP;
    localparam int OMAX = (1 << CW) - 1;
`ifdef GEN_SEC_QUEUE_EN
    localparam bit QEN = 1'b1;
`else
    localparam bit QEN = 1'b0;
`endif

    logic clk = 1'b0, reset = 1'b1, req_ingreso = 1'b0, req_egreso = 1'b0;
    logic a, b, busy, done, conflicto, perdida;
    logic [CW-1:0] ocupacion;

    gen_secuencia_ab #(.STEP_CYCLES(STEP), .CNT_W(CW)) dut (
        .clk         (clk),
        .reset       (reset),
        .req_ingreso (req_ingreso),
        .req_egreso  (req_egreso),
        .a           (a),
        .b           (b),
        .busy        (busy),
        .done        (done),
        .conflicto   (conflicto),
        .perdida     (perdida),
        .ocupacion   (ocupacion)
    );

    always #5 clk = ~clk;

    typedef struct { int fin; int occ; } exp_t;
    exp_t sb[$];

    int total = 0, bad = 0, cyc = 0;

    // model state: active sequence, pending entry, flags, occupancy
    bit activo, pv, perd, conf_e, done_e;
    int t0, cdir, pdir, occ, proj;
    // {a,b} per phase, [0]=ingress [1]=egress
    int tab [2][4] = '{'{2, 3, 1, 0}, '{1, 3, 2, 0}};

    task automatic chk(string nm, int got, int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%0d want=%0d", nm, cyc, got, want);
        end
    endtask

    function automatic int sat(int o, int d);
        if (d != 0) return (o > 0) ? o - 1 : 0;
        return (o < OMAX) ? o + 1 : OMAX;
    endfunction

    task automatic arranca(int d, int t);
        activo = 1'b1;
        t0     = t;
        cdir   = d;
    endtask

    task automatic encola(int d, int fin);
        exp_t e;
        proj  = sat(proj, d);
        e.fin = fin;
        e.occ = proj;
        sb.push_back(e);
    endtask

    // reference model, evaluated at every active edge
    initial forever begin
        int d;
        bit uno;
        @(posedge clk or posedge reset);
        if (clk) cyc++;
        if (reset) begin
            activo = 0; pv = 0; perd = 0; conf_e = 0; done_e = 0;
            occ = 0; proj = 0;
            sb.delete();
        end else begin
            uno    = req_ingreso ^ req_egreso;
            d      = req_egreso ? 1 : 0;
            conf_e = req_ingreso & req_egreso;
            done_e = 1'b0;
            if (activo && cyc == t0 + SEQ) begin
                done_e = 1'b1;
                occ    = sat(occ, cdir);
                activo = 1'b0;
                if (QEN && pv) begin
                    arranca(pdir, cyc);
                    pv = 1'b0;
                    if (uno) perd = 1'b1;
                end else if (QEN && uno) begin
                    arranca(d, cyc);
                    encola(d, cyc + SEQ);
                end else if (uno) begin
                    perd = 1'b1;
                end
            end else if (activo) begin
                if (uno) begin
                    if (QEN && !pv) begin
                        pv   = 1'b1;
                        pdir = d;
                        encola(d, t0 + 2 * SEQ);
                    end else begin
                        perd = 1'b1;
                    end
                end
            end else if (uno) begin
                arranca(d, cyc);
                encola(d, cyc + SEQ);
            end
        end
    end

    // monitor: per-cycle output check plus done scoreboard
    initial forever begin
        int e_ab;
        exp_t e;
        @(negedge clk);
        if (!reset) begin
            e_ab = activo ? tab[cdir][(cyc - t0) / STEP] : 0;
            chk("ab", int'({a, b}), e_ab);
            chk("busy", int'(busy), int'(activo));
            chk("done", int'(done), int'(done_e));
            chk("conflicto", int'(conflicto), int'(conf_e));
            chk("perdida", int'(perdida), int'(perd));
            chk("ocupacion", int'(ocupacion), occ);
            if (done) begin
                if (sb.size() == 0) begin
                    total++; bad++;
                    $display("FAIL done_extra cyc=%0d got=done want=none", cyc);
                end else begin
                    e = sb.pop_front();
                    chk("done_cyc", cyc, e.fin);
                    chk("done_occ", int'(ocupacion), e.occ);
                end
            end else if (sb.size() > 0 && sb[0].fin <= cyc) begin
                total++; bad++;
                $display("FAIL done_missing cyc=%0d got=none want_cyc=%0d", cyc, sb[0].fin);
                void'(sb.pop_front());
            end
        end
    end

    task automatic idle(int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulso(bit i, bit e);
        @(negedge clk);
        req_ingreso = i;
        req_egreso  = e;
        @(negedge clk);
        req_ingreso = 1'b0;
        req_egreso  = 1'b0;
    endtask

    // asserted between edges: outputs must clear without a clock
    task automatic do_reset();
        @(negedge clk);
        req_ingreso = 1'b0;
        req_egreso  = 1'b0;
        reset = 1'b1;
        #1;
        chk("rst_ab", int'({a, b}), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_conf", int'(conflicto), 0);
        chk("rst_perd", int'(perdida), 0);
        chk("rst_occ", int'(ocupacion), 0);
        idle(2);
        reset = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog cyc=%0d got=timeout want=finish", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        int r;
        do_reset();
        // basic ingress, then egress down to 0 and saturation at 0
        pulso(1, 0); idle(SEQ + 2);
        pulso(0, 1); idle(SEQ + 2);
        pulso(0, 1); idle(SEQ + 2);
        // conflict in IDLE
        pulso(1, 1); idle(3);
        // egress during an ingress sequence
        pulso(1, 0); idle(1); pulso(0, 1); idle(2 * SEQ + 4);
        // two extra requests during one sequence
        do_reset();
        pulso(1, 0); pulso(0, 1); pulso(1, 0); idle(3 * SEQ);
        // reset during P2, then a normal run
        do_reset();
        pulso(1, 0); idle(2);
        do_reset();
        pulso(1, 0); idle(SEQ + 2);
        // saturation at the top
        for (int i = 0; i < OMAX + 2; i++) begin
            pulso(1, 0); idle(SEQ);
        end
        // random traffic with occasional resets
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            r = $urandom_range(0, 99);
            req_ingreso = (r < 10) || (r >= 20 && r < 22);
            req_egreso  = (r >= 10 && r < 22);
            if (r == 99 && $urandom_range(0, 7) == 0) do_reset();
        end
        @(negedge clk);
        req_ingreso = 1'b0;
        req_egreso  = 1'b0;
        idle(3 * SEQ);
        chk("sb_drain", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/gen_secuencia_ab.md
# gen_secuencia_ab

Two-sensor sequence generator: the transmitting end of the `a`/`b` passage-detection interface consumed by the ingress/egress detector. On a single-cycle ingress or egress request it drives `a`/`b` through the full four-phase Gray sequence, holding each phase for a programmable number of clock cycles. It keeps a saturating occupancy count of completed passages. It is used as a stimulus source for the detector and as a sensor emulator on the board.

## Interface
- `STEP_CYCLES`, 4: clock cycles each phase is held; must be ≥1.
- `CNT_W`, 8: width of the occupancy counter.
- `clk` in 1: single system clock, rising edge.
- `reset` in 1: asynchronous, active-high; clears all state.
- `req_ingreso` in 1: one-cycle pulse requesting an ingress sequence.
- `req_egreso` in 1: one-cycle pulse requesting an egress sequence.
- `a` out 1: sensor A level, registered.
- `b` out 1: sensor B level, registered.
- `busy` out 1: a sequence is in progress.
- `done` out 1: one-cycle pulse when a sequence completes.
- `conflicto` out 1: one-cycle pulse when both requests are sampled high together.
- `perdida` out 1: sticky flag; a request was dropped. Cleared only by `reset`.
- `ocupacion` out CNT_W: net passages, saturating.

## Operation
- FSM states: IDLE, P1, P2, P3, P4. A direction register `dir` selects ingress or egress.
- Ingress codes `{a,b}`: P1=10, P2=11, P3=01, P4=00.
- Egress codes `{a,b}`: P1=01, P2=11, P3=10, P4=00.
- IDLE drives 00.
- In IDLE, exactly one request sampled high → latch `dir`, go to P1, `busy`=1.
- Both requests high on the same edge → no request accepted, `conflicto` pulses, stay in IDLE. This rule applies in every state.
- Step counter range 0..STEP_CYCLES-1, width `$clog2(STEP_CYCLES)` with a minimum of 1. It reloads on every phase change. The phase advances when the counter reaches STEP_CYCLES-1.
- On leaving P4:
  - `done` pulses.
  - `ocupacion` is updated on the same edge: +1 for ingress, saturating at 2^CNT_W-1; −1 for egress, saturating at 0.
  - Then go to IDLE, or to P1 if a request is pending (see Configuration).
- A request arriving while busy and not bufferable is dropped and sets `perdida`.
- Reset values: state IDLE, `a`=`b`=0, `busy`=0, `done`=0, `conflicto`=0, `perdida`=0, `ocupacion`=0, buffer empty.
- `reset` asserted mid-sequence aborts the sequence immediately. Outputs go to reset values asynchronously. `ocupacion` is not updated for the aborted sequence.

## Timing
- Request sampled at edge k → `a`/`b` show the P1 code and `busy`=1 after edge k. Zero added latency; all outputs are registered.
- Each phase lasts exactly STEP_CYCLES cycles.
- `busy` is high for 4·STEP_CYCLES cycles per sequence.
- `done` and the `ocupacion` update occur at edge k+4·STEP_CYCLES. `busy` falls at that same edge unless a pending request chains.
- When chaining, P1 of the next sequence starts at that edge. `busy` stays high and `done` still pulses.
- A request on the same edge that a sequence completes counts as arriving while busy.
- `conflicto` pulses one cycle after the offending edge. `perdida` sets one cycle after the dropped request's edge.

## Configuration
- `GEN_SEC_QUEUE_EN` defined: one-entry pending-request buffer (valid + direction).
  - A single request while busy is stored if the buffer is empty.
  - If the buffer is full, the request is dropped and `perdida` is set.
  - The stored request starts at the P4 exit, back-to-back.
- Undefined: no buffer. Every request while busy is dropped and sets `perdida`.

## Structure
- Package `gen_secuencia_pkg` holds:
  - State enum `estado_t` (IDLE, P1..P4).
  - Direction enum `dir_t` (DIR_INGRESO, DIR_EGRESO).
  - Phase code constants `COD_ING_P1..P4` and `COD_EGR_P1..P4`.
- Sub-module `div_paso`: the step counter. Inputs: load and enable. Output: one-cycle `fin_paso` tick. All other logic is in the top.

## Test plan
All scenarios use STEP_CYCLES=2.
- Reset, then `req_ingreso` one cycle → `{a,b}` = 10,10,11,11,01,01,00,00 over 8 cycles; `done` pulses at edge 8; `ocupacion`=1; `busy` low afterward.
- `req_egreso` from `ocupacion`=1 → `{a,b}` sequence 01,11,10,00 with 2 cycles each; `ocupacion`=0. A second egress → `ocupacion` stays 0 (saturation).
- `req_ingreso` and `req_egreso` on the same cycle in IDLE → `conflicto` pulses once; `a`/`b` stay 00; `busy`=0.
- `req_egreso` at cycle 3 of an ingress sequence:
  - Without the macro → `perdida`=1, ingress completes alone, `ocupacion`=1.
  - With the macro → egress P1=01 starts at edge 8 with no gap, `done` pulses twice, final `ocupacion`=0.
- With the macro, two extra requests during one sequence → the first is buffered, the second sets `perdida`.
- `reset` asserted during P2 → `a`=`b`=0 and `busy`=0 immediately; `ocupacion` unchanged from pre-sequence value 0; a new request after release runs normally.
